vga_sync_receiver: RTL and testbench

VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

---
 rtl/vga_sync_receiver.sv | 226 ++++++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers pixel coordinates from hsync/vsync/blank_n, measures
// line/frame timing against the parameters and tracks lock with a small FSM.
//
// state  | meaning
// HUNT   | waiting for a vsync fall to start measuring whole frames
// VERIFY | counting consecutive violation-free frames toward LOCK_FRAMES
// LOCKED | timing matches parameters; any violation drops back to HUNT
module vga_sync_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       blank_n,
  input  logic [2:0] rgb_in,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       pixel_valid,
  output logic [2:0] rgb_out,
  output logic       frame_start,
  output logic       locked,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [11:0] H_TOTAL_W  = 12'(H_TOTAL);
  localparam logic [10:0] H_ACTIVE_W = 11'(H_ACTIVE);
  localparam logic [10:0] V_TOTAL_W  = 11'(V_TOTAL);
  localparam logic [7:0]  LOCK_W     = 8'(LOCK_FRAMES);

  // input stage 1 and the stage-2 copy used only for edge detection
  logic       hs1_q, hs1_d, vs1_q, vs1_d, bn1_q, bn1_d;
  logic [2:0] rgb1_q, rgb1_d;
  logic       hs2_q, hs2_d, vs2_q, vs2_d, bn2_q, bn2_d;

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] act_cnt_q, act_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        line_armed_q, line_armed_d;
  state_t      state_q, state_d;
  logic [7:0]  good_frames_q, good_frames_d;

  logic [9:0]  x_pos_q, x_pos_d;
  logic [9:0]  y_pos_q, y_pos_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic [2:0]  rgb_out_q, rgb_out_d;
  logic        frame_start_q, frame_start_d;
  logic        locked_q, locked_d;
  logic [7:0]  err_count_q, err_count_d;

  logic        h_fall, v_fall, b_rise, b_fall;
  logic [11:0] line_len;
  logic [10:0] frame_lines;
  logic        line_viol, frame_viol, viol;
  logic [7:0]  good_inc;

  assign h_fall = hs2_q & ~hs1_q;
  assign v_fall = vs2_q & ~vs1_q;
  assign b_rise = ~bn2_q & bn1_q;
  assign b_fall = bn2_q & ~bn1_q;

  // a vsync fall that coincides with an hsync fall closes that line too
  assign line_len    = {1'b0, h_cnt_q} + 12'd1;
  assign frame_lines = {1'b0, v_cnt_q} + {10'd0, h_fall};
  assign good_inc    = good_frames_q + 8'd1;

  always_comb begin
    hs1_d  = hsync;
    vs1_d  = vsync;
    bn1_d  = blank_n;
    rgb1_d = rgb_in;
    hs2_d  = hs1_q;
    vs2_d  = vs1_q;
    bn2_d  = bn1_q;
  end

  always_comb begin
    h_cnt_d      = h_cnt_q;
    act_cnt_d    = act_cnt_q;
    v_cnt_d      = v_cnt_q;
    line_armed_d = line_armed_q | h_fall;

    if (h_fall) begin
      h_cnt_d = 11'd0;
    end else if (h_cnt_q != 11'h7FF) begin
      h_cnt_d = h_cnt_q + 11'd1;
    end

    if (h_fall) begin
      act_cnt_d = {10'd0, bn1_q};
    end else if (bn1_q && act_cnt_q != 11'h7FF) begin
      act_cnt_d = act_cnt_q + 11'd1;
    end

    if (v_fall) begin
      v_cnt_d = 10'd0;
    end else if (h_fall && v_cnt_q != 10'h3FF) begin
      v_cnt_d = v_cnt_q + 10'd1;
    end
  end

  always_comb begin
    line_viol  = h_fall & line_armed_q &
                 ((line_len != H_TOTAL_W) |
                  ((act_cnt_q != 11'd0) & (act_cnt_q != H_ACTIVE_W)));
    frame_viol = v_fall & (state_q != HUNT) & (frame_lines != V_TOTAL_W);
    viol       = line_viol | frame_viol;

    state_d       = state_q;
    good_frames_d = good_frames_q;
    unique case (state_q)
      HUNT: begin
        if (v_fall) begin
          state_d       = VERIFY;
          good_frames_d = 8'd0;
        end
      end
      VERIFY: begin
        if (viol) begin
          state_d = HUNT;
        end else if (v_fall) begin
          good_frames_d = good_inc;
          if (good_inc >= LOCK_W) begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (viol) begin
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    x_pos_d       = x_pos_q;
    y_pos_d       = y_pos_q;
    pixel_valid_d = bn1_q;
    rgb_out_d     = bn1_q ? rgb1_q : 3'b000;
    frame_start_d = v_fall;
    locked_d      = (state_d == LOCKED);
    err_count_d   = err_count_q;

    if (b_rise) begin
      x_pos_d = 10'd0;
    end else if (bn1_q && x_pos_q != 10'h3FF) begin
      x_pos_d = x_pos_q + 10'd1;
    end

    if (v_fall) begin
      y_pos_d = 10'd0;
    end else if (b_fall && y_pos_q != 10'h3FF) begin
      y_pos_d = y_pos_q + 10'd1;
    end

    if (viol && err_count_q != 8'hFF) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      bn1_q         <= 1'b0;
      rgb1_q        <= 3'b000;
      hs2_q         <= 1'b1;
      vs2_q         <= 1'b1;
      bn2_q         <= 1'b0;
      h_cnt_q       <= 11'd0;
      act_cnt_q     <= 11'd0;
      v_cnt_q       <= 10'd0;
      line_armed_q  <= 1'b0;
      state_q       <= HUNT;
      good_frames_q <= 8'd0;
      x_pos_q       <= 10'd0;
      y_pos_q       <= 10'd0;
      pixel_valid_q <= 1'b0;
      rgb_out_q     <= 3'b000;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      err_count_q   <= 8'd0;
    end else begin
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      bn1_q         <= bn1_d;
      rgb1_q        <= rgb1_d;
      hs2_q         <= hs2_d;
      vs2_q         <= vs2_d;
      bn2_q         <= bn2_d;
      h_cnt_q       <= h_cnt_d;
      act_cnt_q     <= act_cnt_d;
      v_cnt_q       <= v_cnt_d;
      line_armed_q  <= line_armed_d;
      state_q       <= state_d;
      good_frames_q <= good_frames_d;
      x_pos_q       <= x_pos_d;
      y_pos_q       <= y_pos_d;
      pixel_valid_q <= pixel_valid_d;
      rgb_out_q     <= rgb_out_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      err_count_q   <= err_count_d;
    end
  end

  assign x_pos       = x_pos_q;
  assign y_pos       = y_pos_q;
  assign pixel_valid = pixel_valid_q;
  assign rgb_out     = rgb_out_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver: reduced-size VGA timing, randomized pixels and sync
// noise, checked every cycle against a sample-history model plus literal checkpoints.
module tb_vga_sync_receiver;

  localparam int H_T     = 130;
  localparam int V_T     = 60;
  localparam int H_A     = 104;
  localparam int LOCK    = 2;
  localparam int HS_W    = 10;
  localparam int H_ACT0  = 18;
  localparam int V_ACT0  = 5;
  localparam int V_ACT_N = 52;

  logic       clk;
  logic       rst;
  logic       hsync, vsync, blank_n;
  logic [2:0] rgb_in;
  logic       tgt;
  logic [9:0] x_pos, y_pos;
  logic       pixel_valid;
  logic [2:0] rgb_out;
  logic       frame_start, locked;
  logic [7:0] err_count;

  vga_sync_receiver #(
    .H_TOTAL(H_T), .V_TOTAL(V_T), .H_ACTIVE(H_A), .LOCK_FRAMES(LOCK)
  ) u_dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
    .rgb_in(rgb_in), .x_pos(x_pos), .y_pos(y_pos), .pixel_valid(pixel_valid),
    .rgb_out(rgb_out), .frame_start(frame_start), .locked(locked),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int tgt_hits = 0;
  bit pix_en   = 0;
  bit started  = 0;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       pv;
    logic [2:0] rgb;
    logic       fs;
    logic       lk;
    logic [7:0] err;
    logic       tgt;
  } exp_t;

  exp_t exp_d1, exp_cur;

  // model state: plain integers over sample indices
  int   smp = 0;
  logic p_hs, p_vs, p_bn;
  bit   hf_seen;
  int   last_hf, act_n, tot_hf, hf_at_vf, m_st, m_good, m_err, m_x, m_y;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  initial begin : model_proc
    forever begin
      @(posedge clk);
      if (rst) begin
        p_hs = 1; p_vs = 1; p_bn = 0;
        hf_seen = 0; last_hf = 0; act_n = 0; tot_hf = 0; hf_at_vf = 0;
        m_st = 0; m_good = 0; m_err = 0; m_x = 0; m_y = 0;
        exp_d1 = '0; exp_cur = '0; started = 1;
      end else begin : step
        bit hf, vf, br, bf, lv, fv;
        exp_cur = exp_d1;
        hf = p_hs && !hsync;
        vf = p_vs && !vsync;
        br = !p_bn && blank_n;
        bf = p_bn && !blank_n;
        lv = 0;
        fv = 0;
        if (hf) begin
          if (hf_seen) lv = ((smp - last_hf) != H_T) || (act_n != 0 && act_n != H_A);
          hf_seen = 1; last_hf = smp; act_n = 0; tot_hf++;
        end
        if (blank_n) act_n++;
        if (vf) begin
          if (m_st != 0) fv = ((tot_hf - hf_at_vf) != V_T);
          hf_at_vf = tot_hf;
        end
        if (lv || fv) m_err = (m_err < 255) ? m_err + 1 : 255;
        if ((lv || fv) && m_st != 0) m_st = 0;
        else if (vf) begin
          if (m_st == 0) begin m_st = 1; m_good = 0; end
          else if (m_st == 1) begin
            m_good++;
            if (m_good >= LOCK) m_st = 2;
          end
        end
        if (br) m_x = 0;
        else if (blank_n) m_x = (m_x < 1023) ? m_x + 1 : 1023;
        if (vf) m_y = 0;
        else if (bf) m_y = (m_y < 1023) ? m_y + 1 : 1023;
        exp_d1.x   = 10'(m_x);
        exp_d1.y   = 10'(m_y);
        exp_d1.pv  = blank_n;
        exp_d1.rgb = blank_n ? rgb_in : 3'b000;
        exp_d1.fs  = vf;
        exp_d1.lk  = (m_st == 2);
        exp_d1.err = 8'(m_err);
        exp_d1.tgt = tgt;
        p_hs = hsync; p_vs = vsync; p_bn = blank_n;
      end
      smp++;
    end
  end

  initial begin : compare_proc
    forever begin
      @(negedge clk);
      if (started) begin
        checks++;
        if ({x_pos, y_pos, pixel_valid, rgb_out, frame_start, locked, err_count} !==
            {exp_cur.x, exp_cur.y, exp_cur.pv, exp_cur.rgb, exp_cur.fs, exp_cur.lk, exp_cur.err}) begin
          failures++;
          $display("FAIL out_cmp sample=%0d actual x=%0d y=%0d pv=%0b rgb=%0d fs=%0b lk=%0b err=%0d required x=%0d y=%0d pv=%0b rgb=%0d fs=%0b lk=%0b err=%0d",
                   smp, x_pos, y_pos, pixel_valid, rgb_out, frame_start, locked, err_count,
                   exp_cur.x, exp_cur.y, exp_cur.pv, exp_cur.rgb, exp_cur.fs, exp_cur.lk, exp_cur.err);
        end
        if (exp_cur.tgt) begin
          tgt_hits++;
          chk("pix_x", int'(x_pos), 99);
          chk("pix_y", int'(y_pos), 49);
          chk("pix_valid", int'(pixel_valid), 1);
          chk("pix_rgb", int'(rgb_out), 5);
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic hs, input logic vs, input logic bn,
                       input logic [2:0] rgb, input logic t);
    hsync = hs; vsync = vs; blank_n = bn; rgb_in = rgb; tgt = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic line_seg(input int ln, input int c0, input int c1);
    for (int c = c0; c < c1; c++) begin : col
      logic       act;
      logic [2:0] r;
      logic       t;
      act = (ln >= V_ACT0) && (ln < V_ACT0 + V_ACT_N) && (c >= H_ACT0) && (c < H_ACT0 + H_A);
      r = 3'($urandom_range(0, 7));
      t = 1'b0;
      if (pix_en) begin
        if (act && (ln - V_ACT0) == 49 && (c - H_ACT0) == 99) begin
          r = 3'b101;
          t = 1'b1;
        end else if (r == 3'b101) begin
          r = 3'b100;
        end
      end
      drive((c < HS_W) ? 1'b0 : 1'b1, (ln < 2) ? 1'b0 : 1'b1, act, r, t);
    end
  endtask

  task automatic lines(input int l0, input int l1, input int long_ln, input int long_len);
    for (int ln = l0; ln < l1; ln++) begin
      line_seg(ln, 0, (ln == long_ln) ? long_len : H_T);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_x"}, int'(x_pos), 0);
    chk({tag, "_y"}, int'(y_pos), 0);
    chk({tag, "_pv"}, int'(pixel_valid), 0);
    chk({tag, "_rgb"}, int'(rgb_out), 0);
    chk({tag, "_fs"}, int'(frame_start), 0);
    chk({tag, "_lk"}, int'(locked), 0);
    chk({tag, "_err"}, int'(err_count), 0);
  endtask

  initial begin : driver
    logic hs_r, vs_r, bn_r;
    rst = 1'b1; hsync = 1'b1; vsync = 1'b1; blank_n = 1'b0; rgb_in = 3'b000; tgt = 1'b0;
    @(negedge clk);
    repeat (3) drive(1'b1, 1'b1, 1'b0, 3'b111, 1'b0);
    chk_zero_outputs("reset");
    rst = 1'b0;

    // nominal frames: lock expected at the third vsync fall
    lines(0, V_T, -1, 0);
    pix_en = 1;
    lines(0, V_T, -1, 0);
    pix_en = 0;
    chk("pre_lock_locked", int'(locked), 0);
    line_seg(0, 0, 1);
    chk("lock_edge_fs_early", int'(frame_start), 0);
    chk("lock_edge_lk_early", int'(locked), 0);
    line_seg(0, 1, 2);
    chk("lock_fs", int'(frame_start), 1);
    chk("lock_locked", int'(locked), 1);
    chk("lock_err", int'(err_count), 0);
    line_seg(0, 2, H_T);

    // one line stretched by a clock while locked
    lines(1, 21, 20, H_T + 1);
    line_seg(21, 0, 1);
    chk("long_line_lk_hold", int'(locked), 1);
    line_seg(21, 1, 2);
    chk("long_line_lk_drop", int'(locked), 0);
    chk("long_line_err", int'(err_count), 1);
    line_seg(21, 2, H_T);
    lines(22, V_T, -1, 0);
    lines(0, V_T, -1, 0);
    lines(0, V_T, -1, 0);
    line_seg(0, 0, 2);
    chk("relock_locked", int'(locked), 1);
    chk("relock_err", int'(err_count), 1);
    line_seg(0, 2, H_T);

    // single-cycle reset mid-frame while locked
    lines(1, 30, -1, 0);
    line_seg(30, 0, 50);
    rst = 1'b1;
    line_seg(30, 50, 51);
    rst = 1'b0;
    chk_zero_outputs("midrst");
    line_seg(30, 51, H_T);
    lines(31, V_T, -1, 0);
    chk("partial_frame_err", int'(err_count), 0);
    chk("partial_frame_lk", int'(locked), 0);

    // short frame while verifying
    lines(0, V_T - 1, -1, 0);
    line_seg(0, 0, 2);
    chk("short_frame_lk", int'(locked), 0);
    chk("short_frame_err", int'(err_count), 1);
    chk("short_frame_fs", int'(frame_start), 1);
    line_seg(0, 2, H_T);

    // hsync held high for 3000 clocks
    lines(1, 11, 10, HS_W + 3000);
    line_seg(11, 0, 1);
    chk("hold_err_before", int'(err_count), 1);
    line_seg(11, 1, 2);
    chk("hold_err_after", int'(err_count), 2);
    line_seg(11, 2, H_T);
    lines(12, V_T, -1, 0);

    // random sync noise
    hs_r = 1'b1; vs_r = 1'b1; bn_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) hs_r = ~hs_r;
      if ($urandom_range(0, 199) == 0) vs_r = ~vs_r;
      if ($urandom_range(0, 29) == 0) bn_r = ~bn_r;
      drive(hs_r, vs_r, bn_r, 3'($urandom_range(0, 7)), 1'b0);
    end
    repeat (3) drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);

    chk("pix_target_seen", tgt_hits, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
